inst_buf: RTL and testbench

INST_BUF -- requirements
Module: inst_buf

---
 rtl/inst_buf.sv | 59 +++++
 tb/tb_inst_buf.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/inst_buf.sv
// inst_buf: fetch-to-decode FIFO carrying bound {pc, inst} pairs to the decoder.
// Define INST_BUF_BYPASS_EN to pass an instruction straight through an empty buffer.
module inst_buf #(
   parameter int DATA_WIDTH = 64,
   parameter int INST_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_pc,
   input  logic [INST_WIDTH-1:0]     in_inst,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     out_pc,
   output logic [INST_WIDTH-1:0]     out_inst,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [DATA_WIDTH-1:0] r_pc   [DEPTH];
   logic [INST_WIDTH-1:0] r_inst [DEPTH];
   logic [AW-1:0]         r_rd, r_wr;
   logic [AW:0]           r_count;
   logic                  w_byp, w_push, w_pop, w_empty;
   assign w_empty  = (r_count == '0);
`ifdef INST_BUF_BYPASS_EN
   assign w_byp    = w_empty && in_valid && !flush;
`else
   assign w_byp    = 1'b0;
`endif
   assign count    = r_count;
   assign in_ready = (r_count < FULL);
   // a bypassed instruction taken by decode the same cycle is never stored
   assign w_push   = in_valid && in_ready && !flush && !(w_byp && out_ready);
   assign w_pop    = !w_empty && out_ready && !flush;
   assign out_valid = !w_empty || w_byp;
   assign out_pc    = !w_empty ? r_pc[r_rd]   : (w_byp ? in_pc   : '0);
   assign out_inst  = !w_empty ? r_inst[r_rd] : (w_byp ? in_inst : '0);
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc[r_wr]   <= in_pc;
         r_inst[r_wr] <= in_inst;
      end
   end
endmodule

// File: tb/tb_inst_buf.sv
// tb_inst_buf: randomized and directed checks of inst_buf against a queue-based model.
module tb_inst_buf;
   localparam int DEPTH = 4;
`ifdef INST_BUF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [63:0] in_pc = '0;
   logic [31:0] in_inst = '0;
   logic        in_ready, out_valid;
   logic [63:0] out_pc;
   logic [31:0] out_inst;
   logic [2:0]  count;
   int checks = 0, errors = 0;
   logic [95:0] q[$];
   logic        e_v, e_rdy;
   logic [63:0] e_pc;
   logic [31:0] e_inst;
   int          e_c;

   inst_buf #(.DATA_WIDTH(64), .INST_WIDTH(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   // Reference: the buffer is an ordered list of pending {pc, inst} pairs.
   function automatic void mdl_step();
      int c = q.size();
      bit byp = BYP && c == 0 && in_valid;
      if (rst || flush) q.delete();
      else if (!(byp && out_ready)) begin
         if (out_ready && c > 0) void'(q.pop_front());
         if (in_valid && c < DEPTH) q.push_back({in_pc, in_inst});
      end
   endfunction

   function automatic void expect_now();
      e_c = q.size();
      e_rdy = e_c < DEPTH;
      e_v = 1'b0; e_pc = '0; e_inst = '0;
      if (e_c > 0) begin
         e_v = 1'b1; {e_pc, e_inst} = q[0];
      end else if (BYP && in_valid && !flush) begin
         e_v = 1'b1; e_pc = in_pc; e_inst = in_inst;
      end
   endfunction

   task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, input logic rs);
      in_valid = v; in_pc = pc; in_inst = ins; out_ready = ordy; flush = fl; rst = rs;
      #1;
   endtask

   task automatic tick();
      mdl_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1, 64'h99, 32'h99, 0, 0, 1);
      tick();
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (out_pc !== 64'h0 || out_inst !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h/%h want 0/0", out_pc, out_inst); end
   endtask

   task automatic test_single();
      drive(1, 64'h1000, 32'h00500093, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (out_valid !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL single_valid: got v=%b c=%0d want v=1 c=1", out_valid, count); end
      checks++; if (out_pc !== 64'h1000 || out_inst !== 32'h00500093) begin errors++; $display("FAIL single_data: got %h/%h want 1000/00500093", out_pc, out_inst); end
      drive(0, 0, 0, 0, 1, 0);
      tick();
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 4; i++) begin
         drive(1, 64'(i * 4), $urandom, 0, 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL full: got c=%0d rdy=%b want c=4 rdy=0", count, in_ready); end
      drive(1, 64'h10, 32'h1, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_push_ignored: got c=%0d want 4", count); end
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 1, 0, 0);
         expect_now();
         checks++; if (out_valid !== 1'b1 || out_pc !== 64'(i * 4) || out_inst !== e_inst) begin errors++; $display("FAIL drain_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", i, out_valid, out_pc, out_inst, 64'(i * 4), e_inst); end
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (out_valid !== 1'b0 || count !== 3'd0 || out_pc !== 64'h0) begin errors++; $display("FAIL drained_empty: got v=%b c=%0d pc=%h want 0/0/0", out_valid, count, out_pc); end
   endtask

   task automatic test_back_to_back();
      drive(1, 64'h100, 32'hA0, 0, 0, 0); tick();
      drive(1, 64'h104, 32'hA1, 0, 0, 0); tick();
      for (int i = 0; i < 8; i++) begin
         drive(1, 64'h20 + 64'(4 * i), 32'hB0 + 32'(i), 1, 0, 0);
         expect_now();
         checks++; if (out_pc !== e_pc || out_inst !== e_inst) begin errors++; $display("FAIL b2b_head_%0d: got %h/%h want %h/%h", i, out_pc, out_inst, e_pc, e_inst); end
         tick();
         drive(0, 0, 0, 0, 0, 0);
         checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count_%0d: got %0d want 2", i, count); end
      end
      // the last two pushes are what remain, in order
      for (int i = 6; i < 8; i++) begin
         drive(0, 0, 0, 1, 0, 0);
         checks++; if (out_valid !== 1'b1 || out_pc !== 64'h20 + 64'(4 * i)) begin errors++; $display("FAIL b2b_tail_%0d: got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, 64'h20 + 64'(4 * i)); end
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive(1, 64'h200 + 64'(4 * i), $urandom, 0, 0, 0);
         tick();
      end
      drive(1, 64'hDEAD, 32'hDEADBEEF, 0, 1, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush: got c=%0d v=%b want 0/0", count, out_valid); end
      drive(1, 64'h300, 32'h13, 0, 0, 0);
      tick();
      drive(0, 0, 0, 1, 0, 0);
      checks++; if (out_pc !== 64'h300 || count !== 3'd1) begin errors++; $display("FAIL flush_dropped: got pc=%h c=%0d want pc=300 c=1", out_pc, count); end
      tick();
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_bypass();
      drive(1, 64'h40, 32'hFE010113, 1, 0, 0);
      checks++; if (out_valid !== BYP || out_inst !== (BYP ? 32'hFE010113 : 32'h0)) begin errors++; $display("FAIL bypass_same_cycle: got v=%b inst=%h want v=%b", out_valid, out_inst, BYP); end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (count !== (BYP ? 3'd0 : 3'd1) || out_valid !== !BYP) begin errors++; $display("FAIL bypass_next: got c=%0d v=%b want c=%0d v=%b", count, out_valid, BYP ? 0 : 1, !BYP); end
      if (!BYP) begin
         checks++; if (out_pc !== 64'h40 || out_inst !== 32'hFE010113) begin errors++; $display("FAIL bypass_stored: got %h/%h want 40/fe010113", out_pc, out_inst); end
      end
      drive(0, 0, 0, 0, 1, 0);
      tick();
   endtask

   task automatic test_rst_flush();
      drive(1, 64'h500, 32'h1, 0, 0, 0); tick();
      drive(1, 64'h504, 32'h2, 0, 0, 0); tick();
      drive(1, 64'h508, 32'h3, 0, 1, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_pc !== 64'h0) begin errors++; $display("FAIL rst_flush: got c=%0d rdy=%b v=%b pc=%h want 0/1/0/0", count, in_ready, out_valid, out_pc); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom,
               $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 63) == 0);
         expect_now();
         checks++; if (out_valid !== e_v || out_pc !== e_pc || out_inst !== e_inst) begin errors++; $display("FAIL rand_out_%0d: got v=%b %h/%h want v=%b %h/%h", n, out_valid, out_pc, out_inst, e_v, e_pc, e_inst); end
         checks++; if (count !== 3'(e_c) || in_ready !== e_rdy) begin errors++; $display("FAIL rand_occ_%0d: got c=%0d rdy=%b want c=%0d rdy=%b", n, count, in_ready, e_c, e_rdy); end
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_drain();
      test_back_to_back();
      test_flush();
      test_bypass();
      test_rst_flush();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
